// File: rtl/fir_tdm_pkg.sv
// -----------------------------------------------------------------------------
// fir_tdm_pkg
//   Shared types and helpers for the time-multiplexed FIR filter.
//   - state_t   : controller states (IDLE, MAC, OUT)
//   - accw()    : accumulator width that cannot overflow for TAPS products
//   - sat_shift : arithmetic right shift followed by a clamp to a signed
//                 range of a given output width (used when FIR_TDM_SAT_EN
//                 is defined)
// -----------------------------------------------------------------------------
package fir_tdm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Working width for the saturation helper; wide enough for any legal
   // accumulator (DW + CW + 8 bits).
   localparam int SAT_W = 64;

   function automatic int accw(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

   // Shift right arithmetically, then clamp to [-2^(ow-1), 2^(ow-1)-1].
   // The caller truncates the returned value to ow bits.
   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      shift,
      input int                      ow
   );
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      shifted = acc >>> shift;
      hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      if (shifted > hi) begin
         return hi;
      end else if (shifted < lo) begin
         return lo;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/fir_tdm_mac.sv
// -----------------------------------------------------------------------------
// fir_tdm_mac
//   Registered signed multiply-accumulate unit with output stage.
//   Build option: FIR_TDM_SAT_EN (defined -> clamp the shifted accumulator to
//   the OW-bit signed range; undefined -> truncate and wrap).
//
// Ports
//   clk        : clock, rising edge
//   srst       : synchronous active-high reset (clears all state)
//   clear_i    : zero the accumulator for a new sample
//   mul_en_i   : register coef_i * sample_i this cycle
//   load_i     : capture the shifted/saturated accumulator into out_data_o
//   coef_i     : coefficient h[k]
//   sample_i   : delayed sample x[n-k]
//   out_data_o : registered result, held until the next load
// -----------------------------------------------------------------------------
module fir_tdm_mac
   import fir_tdm_pkg::*;
#(
   parameter int DW    = 10,
   parameter int CW    = 10,
   parameter int ACCW  = 26,
   parameter int OW    = 20,
   parameter int SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 clear_i,
   input  logic                 mul_en_i,
   input  logic                 load_i,
   input  logic signed [CW-1:0] coef_i,
   input  logic signed [DW-1:0] sample_i,
   output logic signed [OW-1:0] out_data_o
);

   logic signed [DW+CW-1:0] prod_q, prod_d;
   logic                    prod_vld_q;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic signed [OW-1:0]    out_q, out_d;

`ifdef FIR_TDM_SAT_EN
   logic signed [SAT_W-1:0] acc_wide;
   assign acc_wide = SAT_W'(acc_q);
`endif

   always_comb begin
      prod_d = coef_i * sample_i;
      acc_d  = acc_q;
      // The product registered last cycle is folded in one cycle later, so
      // the accumulator trails the multiplier by one stage.
      if (clear_i) begin
         acc_d = '0;
      end else if (prod_vld_q) begin
         acc_d = acc_q + ACCW'(prod_q);
      end
`ifdef FIR_TDM_SAT_EN
      out_d = OW'(sat_shift(acc_wide, SHIFT, OW));
`else
      out_d = OW'(acc_q >>> SHIFT);
`endif
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         out_q      <= '0;
      end else begin
         prod_vld_q <= mul_en_i;
         if (mul_en_i) begin
            prod_q <= prod_d;
         end
         acc_q <= acc_d;
         if (load_i) begin
            out_q <= out_d;
         end
      end
   end

   assign out_data_o = out_q;

endmodule

// File: rtl/fir_tdm.sv
// -----------------------------------------------------------------------------
// fir_tdm
//   Time-multiplexed FIR filter: y[n] = sum_{k=0..TAPS-1} h[k] * x[n-k],
//   computed with one registered MAC iterated over the taps.
//   Build option: FIR_TDM_SAT_EN (saturating output instead of wrapping).
//
// Ports
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   in_valid   : sample offered          in_ready  : block is idle
//   in_data    : sample x[n] (signed DW)
//   out_valid  : result available        out_ready : consumer takes result
//   out_data   : result y[n] (signed OW), held while out_valid && !out_ready
//   coef_we    : coefficient write strobe (honoured in IDLE only)
//   coef_addr  : tap index k (addresses >= TAPS are ignored)
//   coef_data  : new value for h[k]
//
// Latency: out_valid rises TAPS+2 cycles after the accept edge.
// -----------------------------------------------------------------------------
module fir_tdm
   import fir_tdm_pkg::*;
#(
   parameter int TAPS  = 63,
   parameter int DW    = 10,
   parameter int CW    = 10,
   parameter int OW    = 20,
   parameter int SHIFT = 0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DW-1:0]     in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OW-1:0]     out_data,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [CW-1:0]     coef_data
);

   localparam int AW   = $clog2(TAPS);
   // k runs two steps past the last tap: one drain cycle for the final
   // product and one cycle to load the output register.
   localparam int KW   = $clog2(TAPS + 2);
   localparam int ACCW = accw(DW, CW, TAPS);

   localparam logic [AW-1:0] LAST_IDX    = AW'(TAPS - 1);
   localparam logic [KW-1:0] K_ISSUE_END = KW'(TAPS);
   localparam logic [KW-1:0] K_LAST      = KW'(TAPS + 1);

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic [AW-1:0]        wp_q, wp_d;
   logic [AW-1:0]        rd_q, rd_d;

   logic signed [DW-1:0] dline_q [TAPS];
   // Coefficient store: not reset, contents survive RST. Read
   // asynchronously so the tap loop needs no extra read stage.
   logic signed [CW-1:0] h_mem [TAPS];

   logic                 accept;
   logic                 coef_wr;
   logic                 mul_en;
   logic                 out_load;
   logic signed [DW-1:0] x_rd;
   logic signed [CW-1:0] h_rd;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign accept    = in_valid && (state_q == IDLE);
   assign coef_wr   = coef_we && (state_q == IDLE)
                      && ({1'b0, coef_addr} < (AW+1)'(TAPS));
   assign mul_en    = (state_q == MAC) && (k_q < K_ISSUE_END);
   assign out_load  = (state_q == MAC) && (k_q == K_LAST);

   assign x_rd = dline_q[rd_q];
   assign h_rd = h_mem[k_q[AW-1:0]];

   // ---------------------------------------------------------------- control
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      wp_d    = wp_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               k_d     = '0;
               // Newest sample is x[n-0]; the read pointer walks backwards
               // from the slot it is written into.
               rd_d    = wp_q;
               wp_d    = (wp_q == LAST_IDX) ? '0 : wp_q + 1'b1;
            end
         end
         MAC: begin
            k_d = k_q + 1'b1;
            if (mul_en) begin
               rd_d = (rd_q == '0) ? LAST_IDX : rd_q - 1'b1;
            end
            if (out_load) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         k_q     <= '0;
         wp_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         wp_q    <= wp_d;
         rd_q    <= rd_d;
      end
   end

   // ------------------------------------------------------------- delay line
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < TAPS; i++) begin
            dline_q[i] <= '0;
         end
      end else if (accept) begin
         dline_q[wp_q] <= in_data;
      end
   end

   // ----------------------------------------------------- coefficient store
   // A write coinciding with an accept lands before the first tap read, so
   // the new coefficient is used by that computation.
   always_ff @(posedge CLK) begin
      if (coef_wr) begin
         h_mem[coef_addr] <= coef_data;
      end
   end

   // -------------------------------------------------------------- datapath
   fir_tdm_mac #(
      .DW    (DW),
      .CW    (CW),
      .ACCW  (ACCW),
      .OW    (OW),
      .SHIFT (SHIFT)
   ) u_mac (
      .clk        (CLK),
      .srst       (RST),
      .clear_i    (accept),
      .mul_en_i   (mul_en),
      .load_i     (out_load),
      .coef_i     (h_rd),
      .sample_i   (x_rd),
      .out_data_o (out_data)
   );

endmodule

// File: tb/tb_fir_tdm.sv
`timescale 1ns/1ps
module tb_fir_tdm;

   localparam int TAPS  = 63;
   localparam int DW    = 10;
   localparam int CW    = 10;
   localparam int OW    = 16;
   localparam int SHIFT = 0;
   localparam int AW    = $clog2(TAPS);
   localparam int LIMIT = 200;

   logic                 CLK       = 1'b0;
   logic                 RST       = 1'b1;
   logic                 in_valid  = 1'b0;
   logic                 out_ready = 1'b1;
   logic                 coef_we   = 1'b0;
   logic signed [DW-1:0] in_data   = '0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic                 in_ready;
   logic                 out_valid;
   logic signed [OW-1:0] out_data;

   int     total = 0;
   int     bad   = 0;
   longint sb[$];
   longint h_model[TAPS];
   longint x_hist[TAPS];

   always #5 CLK = ~CLK;

   fir_tdm #(
      .TAPS (TAPS), .DW (DW), .CW (CW), .OW (OW), .SHIFT (SHIFT)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 3ms");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: shift history, convolve, shift, wrap or clamp.
   task automatic model_accept(input longint x);
      longint               sum;
      longint               hi;
      logic signed [OW-1:0] w;
      for (int k = TAPS - 1; k > 0; k--) x_hist[k] = x_hist[k-1];
      x_hist[0] = x;
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += h_model[k] * x_hist[k];
      sum = sum >>> SHIFT;
`ifdef FIR_TDM_SAT_EN
      hi = (longint'(1) <<< (OW - 1)) - 1;
      if (sum > hi) sum = hi;
      else if (sum < -hi - 1) sum = -hi - 1;
`else
      hi = 0;
      w   = sum[OW-1:0];
      sum = w;
`endif
      sb.push_back(sum);
   endtask

   task automatic reset_dut();
      RST = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < TAPS; i++) x_hist[i] = 0;
      sb.delete();
   endtask

   task automatic write_coef(input int addr, input longint val);
      coef_we = 1'b1; coef_addr = AW'(addr); coef_data = CW'(val);
      tick();
      coef_we = 1'b0;
      if (addr < TAPS) h_model[addr] = val;
   endtask

   // One full transaction. in_valid stays high with junk data during
   // MAC/OUT to confirm it is not consumed.
   task automatic send_sample(input longint x, input int hold, input bit cw_en,
                              input int cw_addr, input longint cw_val, input bit mac_poke);
      int                   n;
      longint               exp_v;
      logic signed [OW-1:0] held;
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; in_data = DW'(x);
      if (cw_en) begin
         coef_we = 1'b1; coef_addr = AW'(cw_addr); coef_data = CW'(cw_val);
         if (cw_addr < TAPS) h_model[cw_addr] = cw_val;
      end
      if (hold > 0) out_ready = 1'b0;
      model_accept(x);
      tick();
      coef_we = 1'b0; in_data = DW'(123);
      n = 0;
      while (!out_valid && n < LIMIT) begin
         if (mac_poke && n == 10) begin
            coef_we = 1'b1; coef_addr = '0; coef_data = CW'(77);
         end else begin
            coef_we = 1'b0;
         end
         tick();
         n++;
      end
      coef_we = 1'b0;
      chk("latency", n, TAPS + 2);
      if (!out_valid) begin
         in_valid = 1'b0; out_ready = 1'b1;
         return;
      end
      exp_v = sb.pop_front();
      $display("sample x=%0d -> y=%0d (expected %0d) after %0d cycles", x, out_data, exp_v, n);
      chk("out_data", out_data, exp_v);
      chk("in_ready_busy", in_ready, 0);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, held);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
   endtask

   initial begin
      for (int i = 0; i < TAPS; i++) begin
         x_hist[i] = 0; h_model[i] = 0;
      end
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      RST = 1'b0;

      // Impulse response with h[k] = k+1; out-of-range write must be ignored.
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      write_coef(63, 500);
      send_sample(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < TAPS - 1; i++) send_sample(0, 0, 0, 0, 0, 0);

      // Coefficient write during MAC ignored; next result reveals any leak.
      send_sample(5, 0, 0, 0, 0, 1);
      send_sample(2, 0, 0, 0, 0, 0);
      // Write coincident with accept is used by that computation.
      send_sample(3, 0, 1, 0, -7, 0);
      write_coef(0, 1);

      // Backpressure for 20 cycles.
      send_sample(9, 20, 0, 0, 0, 0);

      // Reset 30 cycles into MAC, then a clean impulse.
      in_valid = 1'b1; in_data = DW'(4);
      model_accept(4);
      tick();
      in_valid = 1'b0;
      repeat (30) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rst_mac_out_valid", out_valid, 0);
      chk("rst_mac_in_ready", in_ready, 1);
      for (int i = 0; i < TAPS; i++) x_hist[i] = 0;
      sb.delete();
      send_sample(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) send_sample(0, 0, 0, 0, 0, 0);

      // DC ramp with negative coefficients, across delay-line wrap.
      reset_dut();
      for (int k = 0; k < TAPS; k++) write_coef(k, -1);
      for (int i = 0; i < 70; i++) send_sample(511, 0, 0, 0, 0, 0);

      // Full-scale: history is all 511, set h = 511.
      for (int k = 0; k < TAPS; k++) write_coef(k, 511);
      send_sample(511, 0, 0, 0, 0, 0);
      send_sample(-512, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
